// File: rtl/sap_pkg.sv
// Shared defaults and helpers for the SAP fetch-path blocks.
package sap_pkg;

    localparam int SAP_WIDTH = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with depth counter and full/empty flags.
module ret_stack
    import sap_pkg::*;
#(
    parameter int WIDTH = SAP_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DW = clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [DW-1:0]    depth;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = AW'(depth);
    assign rd_idx = AW'(depth - DW'(1));

    assign empty = (depth == '0);
    assign full  = (depth == DW'(DEPTH));

    // Storage is deliberately left unreset; it is only read when depth > 0.
    assign dout = empty ? '0 : mem[rd_idx];

    always_ff @(negedge clk_n) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(negedge clk_n) begin
        if (clr) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DW'(1);
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/program_counter_ext.sv
// SAP program counter with jump, CALL/RET return stack and tri-state bus drive.
module program_counter_ext
    import sap_pkg::*;
#(
    parameter int               WIDTH     = SAP_WIDTH,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk_n,
    input  logic             clr,
    input  logic             cp,
    input  logic             ep,
    input  logic             lp,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] w_bus_in,
    output logic [WIDTH-1:0] w_bus,
    output logic [WIDTH-1:0] pc,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] stk_dout;
    logic             do_push;
    logic             do_pop;
    logic             err_set;

    assign pc_inc = pc + WIDTH'(1);

    // Priority: call&ret conflict > ret > call > lp > cp; losers are dropped.
    always_comb begin
        pc_next = pc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        err_set = 1'b0;
        if (call && ret) begin
            err_set = 1'b1;
        end else if (ret) begin
            if (stk_empty) begin
                err_set = 1'b1;
            end else begin
                do_pop  = 1'b1;
                pc_next = stk_dout;
            end
        end else if (call) begin
            if (stk_full) begin
                err_set = 1'b1;
            end else begin
                do_push = 1'b1;
                pc_next = w_bus_in;
            end
        end else if (lp) begin
            pc_next = w_bus_in;
        end else if (cp) begin
            pc_next = pc_inc;
        end
    end

    always_ff @(negedge clk_n) begin
        if (clr) begin
            pc      <= RESET_VEC;
            stk_err <= 1'b0;
        end else begin
            pc <= pc_next;
            if (err_set) begin
                stk_err <= 1'b1;
            end
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk_n (clk_n),
        .clr   (clr),
        .push  (do_push && !clr),
        .pop   (do_pop && !clr),
        .din   (pc_inc),
        .dout  (stk_dout),
        .empty (stk_empty),
        .full  (stk_full)
    );

    assign w_bus = ep ? pc : 'z;

endmodule

// File: tb/tb_program_counter_ext.sv
// Directed bench for program_counter_ext (WIDTH=4, DEPTH=2; second instance with RESET_VEC=4).
module tb_program_counter_ext;

    logic       clk_n;
    logic       clr;
    logic       cp;
    logic       ep;
    logic       lp;
    logic       call;
    logic       ret;
    logic [3:0] w_bus_in;
    wire  [3:0] w_bus;
    wire  [3:0] w_bus4;
    logic [3:0] pc;
    logic [3:0] pc4;
    logic       stk_empty, stk_full, stk_err;
    logic       stk_empty4, stk_full4, stk_err4;

    int n_checks = 0;
    int n_pass   = 0;

    program_counter_ext #(.WIDTH(4), .DEPTH(2), .RESET_VEC(4'd0)) dut (
        .clk_n     (clk_n),
        .clr       (clr),
        .cp        (cp),
        .ep        (ep),
        .lp        (lp),
        .call      (call),
        .ret       (ret),
        .w_bus_in  (w_bus_in),
        .w_bus     (w_bus),
        .pc        (pc),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err)
    );

    program_counter_ext #(.WIDTH(4), .DEPTH(2), .RESET_VEC(4'd4)) dut_rv4 (
        .clk_n     (clk_n),
        .clr       (clr),
        .cp        (cp),
        .ep        (ep),
        .lp        (lp),
        .call      (call),
        .ret       (ret),
        .w_bus_in  (w_bus_in),
        .w_bus     (w_bus4),
        .pc        (pc4),
        .stk_empty (stk_empty4),
        .stk_full  (stk_full4),
        .stk_err   (stk_err4)
    );

    initial begin
        clk_n = 1'b1;
        forever #5 clk_n = ~clk_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_n);
        #1;
    endtask

    task automatic idle();
        clr = 0; cp = 0; ep = 0; lp = 0; call = 0; ret = 0;
    endtask

    initial begin
        idle();
        w_bus_in = 4'd0;

        // 1. reset then count through the wrap
        clr = 1;
        tick();
        check("rst_pc", pc, 0);
        check("rst_empty", stk_empty, 1);
        check("rst_full", stk_full, 0);
        check("rst_err", stk_err, 0);
        check("rst_pc_rv4", pc4, 4);
        clr = 0;
        cp  = 1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check($sformatf("count_%0d", i), pc, i % 16);
        end
        cp = 0;
        ep = 1;
        #1;
        check("wbus_ep", w_bus, 1);

        // 2. jump, and jump beating count
        idle();
        lp = 1; w_bus_in = 4'd3;
        tick();
        check("lp_3", pc, 3);
        ep = 1;
        #1;
        check("wbus_ep_3", w_bus, 3);
        ep = 0;
        cp = 1; w_bus_in = 4'd9;
        tick();
        check("lp_beats_cp", pc, 9);

        // 3. call / ret
        idle();
        lp = 1; w_bus_in = 4'd5;
        tick();
        lp = 0; call = 1; w_bus_in = 4'd12;
        tick();
        check("call_pc", pc, 12);
        check("call_empty", stk_empty, 0);
        call = 0; ret = 1;
        tick();
        check("ret_pc", pc, 6);
        check("ret_empty", stk_empty, 1);

        // 4. nested calls and overflow (pc=6)
        ret = 0; call = 1; w_bus_in = 4'd8;
        tick();
        check("nest1_pc", pc, 8);
        check("nest1_full", stk_full, 0);
        w_bus_in = 4'd10;
        tick();
        check("nest2_pc", pc, 10);
        check("nest2_full", stk_full, 1);
        check("nest2_err", stk_err, 0);
        w_bus_in = 4'd3;
        tick();
        check("ovf_pc", pc, 10);
        check("ovf_err", stk_err, 1);
        call = 0; ret = 1;
        tick();
        check("unnest1_pc", pc, 9);
        check("unnest1_full", stk_full, 0);
        tick();
        check("unnest2_pc", pc, 7);
        check("unnest2_empty", stk_empty, 1);

        // 5. underflow, sticky error, conflict
        idle();
        clr = 1;
        tick();
        check("clr_err", stk_err, 0);
        clr = 0; lp = 1; w_bus_in = 4'd5;
        tick();
        lp = 0; ret = 1;
        tick();
        check("unf_pc", pc, 5);
        check("unf_err", stk_err, 1);
        ret = 0; cp = 1;
        tick();
        check("sticky_pc", pc, 6);
        check("sticky_err", stk_err, 1);
        cp = 0; call = 1; ret = 1; w_bus_in = 4'd2;
        tick();
        check("conf_pc", pc, 6);
        check("conf_empty", stk_empty, 1);
        idle();
        clr = 1;
        tick();
        clr = 0; call = 1; ret = 1; w_bus_in = 4'd2;
        tick();
        check("conf_only_pc", pc, 0);
        check("conf_only_err", stk_err, 1);

        // 6. clr mid-nesting
        idle();
        clr = 1;
        tick();
        clr = 0; call = 1; w_bus_in = 4'd6;
        tick();
        check("mid_call_pc", pc, 6);
        ret = 1;
        tick();
        check("mid_conf_pc", pc, 6);
        check("mid_conf_err", stk_err, 1);
        check("mid_conf_empty", stk_empty, 0);
        call = 0; ret = 0; cp = 1;
        tick();
        check("mid_cp_pc", pc, 7);
        clr = 1;
        tick();
        check("mid_clr_pc", pc, 0);
        check("mid_clr_empty", stk_empty, 1);
        check("mid_clr_err", stk_err, 0);
        check("mid_clr_pc_rv4", pc4, 4);
        check("mid_clr_empty_rv4", stk_empty4, 1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
